// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller: moves the PWM duty toward a commanded target in
// STEP increments every DIV PWM periods, or in a single jump for immediate commands.
module pwm_ramp_ctrl #(
  parameter int unsigned STEP = 1,
  parameter int unsigned DIV  = 4
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       PERIOD_START,
  input  logic       CMD_VALID,
  input  logic [7:0] CMD_DUTY,
  input  logic       CMD_IMMEDIATE,
  output logic       CMD_READY,
  input  logic       ABORT,
  output logic [7:0] PWM_DCycle,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam logic [7:0]        DIV_LAST = 8'(DIV - 1);
  localparam logic signed [9:0] STEP_S   = 10'(STEP);

  state_t     state_q, state_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       imm_q, imm_d;
  logic       done_q, done_d;

  // One STEP toward the target, clamped at the target; the signed width keeps
  // both 255+STEP and 0-STEP representable so neither direction can wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [9:0] cur_s, tgt_s, nxt_s;
    cur_s = $signed({2'b00, cur});
    tgt_s = $signed({2'b00, tgt});
    if (tgt_s > cur_s) begin
      nxt_s = cur_s + STEP_S;
      if (nxt_s > tgt_s) nxt_s = tgt_s;
    end else begin
      nxt_s = cur_s - STEP_S;
      if (nxt_s < tgt_s) nxt_s = tgt_s;
    end
    return 8'(nxt_s);
  endfunction

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      duty_q  <= 8'd0;
      tgt_q   <= 8'd0;
      cnt_q   <= 8'd0;
      imm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      imm_q   <= imm_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    imm_d   = imm_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          tgt_d = CMD_DUTY;
          imm_d = CMD_IMMEDIATE;
          if (CMD_DUTY == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
            cnt_d   = 8'd0;
          end
        end
      end
      RAMP: begin
        // ABORT wins over a coincident period boundary: no update that cycle.
        if (ABORT) begin
          state_d = IDLE;
        end else if (PERIOD_START) begin
          if (imm_q) begin
            duty_d  = tgt_q;
            cnt_d   = 8'd0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (cnt_q == DIV_LAST) begin
            cnt_d  = 8'd0;
            duty_d = step_toward(duty_q, tgt_q);
            if (duty_d == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign CMD_READY  = (state_q == IDLE);
  assign BUSY       = (state_q == RAMP);
  assign DONE       = done_q;
  assign PWM_DCycle = duty_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: four instances with different STEP/DIV, directed
// scenarios plus randomized traffic against an integer reference model.
module tb_pwm_ramp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ps   [4];
  logic       cv   [4];
  logic       ci   [4];
  logic       ab   [4];
  logic [7:0] cd   [4];
  logic       rdy  [4];
  logic       busy [4];
  logic       done [4];
  logic [7:0] duty [4];

  int tests = 0;
  int fails = 0;

  int tb_step [4] = '{1, 3, 100, 1};
  int tb_div  [4] = '{1, 1, 1, 4};

  int m_duty [4];
  int m_tgt [4];
  int m_pulses [4];
  bit m_busy [4];
  bit m_imm [4];
  bit m_done [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned G_STEP = (g == 2) ? 100 : (g == 1) ? 3 : 1;
    localparam int unsigned G_DIV  = (g == 3) ? 4 : 1;
    pwm_ramp_ctrl #(.STEP(G_STEP), .DIV(G_DIV)) dut (
      .CLK_IN       (clk),
      .RST_N        (rst_n),
      .PERIOD_START (ps[g]),
      .CMD_VALID    (cv[g]),
      .CMD_DUTY     (cd[g]),
      .CMD_IMMEDIATE(ci[g]),
      .CMD_READY    (rdy[g]),
      .ABORT        (ab[g]),
      .PWM_DCycle   (duty[g]),
      .BUSY         (busy[g]),
      .DONE         (done[g])
    );
  end

  task automatic idle_inputs();
    for (int k = 0; k < 4; k++) begin
      ps[k] = 1'b0; cv[k] = 1'b0; ci[k] = 1'b0; ab[k] = 1'b0; cd[k] = 8'd0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_duty[k] = 0; m_tgt[k] = 0; m_pulses[k] = 0;
      m_busy[k] = 1'b0; m_imm[k] = 1'b0; m_done[k] = 1'b0;
    end
  endtask

  // Model the effect of the current inputs at the next edge, then cross it.
  task automatic advance();
    for (int k = 0; k < 4; k++) begin
      m_done[k] = 1'b0;
      if (!m_busy[k]) begin
        if (cv[k]) begin
          m_tgt[k] = int'(cd[k]);
          m_imm[k] = ci[k];
          if (m_tgt[k] == m_duty[k]) m_done[k] = 1'b1;
          else begin
            m_busy[k] = 1'b1;
            m_pulses[k] = 0;
          end
        end
      end else if (ab[k]) begin
        m_busy[k] = 1'b0;
      end else if (ps[k]) begin
        m_pulses[k]++;
        if (m_imm[k]) m_duty[k] = m_tgt[k];
        else if (m_pulses[k] == tb_div[k]) begin
          m_pulses[k] = 0;
          if (m_tgt[k] > m_duty[k])
            m_duty[k] = (m_duty[k] + tb_step[k] > m_tgt[k]) ? m_tgt[k] : m_duty[k] + tb_step[k];
          else
            m_duty[k] = (m_duty[k] - tb_step[k] < m_tgt[k]) ? m_tgt[k] : m_duty[k] - tb_step[k];
        end
        if (m_duty[k] == m_tgt[k]) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (duty[k] !== 8'd0 || rdy[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_async[%0d]: duty=%0d rdy=%b busy=%b done=%b, expected 0 1 0 0",
                 k, duty[k], rdy[k], busy[k], done[k]);
      end
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (duty[k] !== 8'd0 || rdy[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_release[%0d]: duty=%0d rdy=%b busy=%b done=%b, expected 0 1 0 0",
                 k, duty[k], rdy[k], busy[k], done[k]);
      end
    end
  endtask

  task automatic test_step1_ramp();
    cv[0] = 1'b1; cd[0] = 8'd4;
    advance();
    cv[0] = 1'b0;
    tests++;
    if (busy[0] !== 1'b1 || rdy[0] !== 1'b0 || duty[0] !== 8'd0) begin
      fails++;
      $display("FAIL step1_accept: busy=%b rdy=%b duty=%0d, expected 1 0 0", busy[0], rdy[0], duty[0]);
    end
    for (int i = 0; i < 4; i++) begin
      ps[0] = 1'b1;
      advance();
      ps[0] = 1'b0;
      tests++;
      if (duty[0] !== 8'(i + 1) || done[0] !== (i == 3) || busy[0] !== (i != 3)) begin
        fails++;
        $display("FAIL step1_seq[%0d]: duty=%0d done=%b busy=%b, expected duty=%0d done=%b busy=%b",
                 i, duty[0], done[0], busy[0], i + 1, (i == 3), (i != 3));
      end
      advance();
      tests++;
      if (duty[0] !== 8'(i + 1) || done[0] !== 1'b0) begin
        fails++;
        $display("FAIL step1_hold[%0d]: duty=%0d done=%b, expected duty=%0d done=0",
                 i, duty[0], done[0], i + 1);
      end
    end
  endtask

  task automatic test_saturate_up();
    int exp_seq [4];
    exp_seq = '{3, 6, 9, 10};
    cv[1] = 1'b1; cd[1] = 8'd10;
    advance();
    cv[1] = 1'b0;
    ps[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      advance();
      tests++;
      if (duty[1] !== 8'(exp_seq[i]) || done[1] !== (i == 3) || busy[1] !== (i != 3)) begin
        fails++;
        $display("FAIL sat_up[%0d]: duty=%0d done=%b busy=%b, expected duty=%0d done=%b busy=%b",
                 i, duty[1], done[1], busy[1], exp_seq[i], (i == 3), (i != 3));
      end
    end
    ps[1] = 1'b0;
    advance();
  endtask

  task automatic test_no_wrap_down();
    int exp_seq [3];
    exp_seq = '{150, 50, 0};
    cv[2] = 1'b1; cd[2] = 8'd250; ci[2] = 1'b1;
    advance();
    cv[2] = 1'b0; ci[2] = 1'b0;
    ps[2] = 1'b1;
    advance();
    ps[2] = 1'b0;
    tests++;
    if (duty[2] !== 8'd250 || done[2] !== 1'b1) begin
      fails++;
      $display("FAIL down_preload: duty=%0d done=%b, expected 250 1", duty[2], done[2]);
    end
    cv[2] = 1'b1; cd[2] = 8'd0;
    advance();
    cv[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps[2] = 1'b1;
      advance();
      ps[2] = 1'b0;
      tests++;
      if (duty[2] !== 8'(exp_seq[i]) || done[2] !== (i == 2)) begin
        fails++;
        $display("FAIL down_seq[%0d]: duty=%0d done=%b, expected duty=%0d done=%b",
                 i, duty[2], done[2], exp_seq[i], (i == 2));
      end
      advance();
    end
    cv[2] = 1'b1; cd[2] = 8'd0;
    advance();
    cv[2] = 1'b0;
    tests++;
    if (done[2] !== 1'b1 || busy[2] !== 1'b0 || rdy[2] !== 1'b1 || duty[2] !== 8'd0) begin
      fails++;
      $display("FAIL same_duty_cmd: done=%b busy=%b rdy=%b duty=%0d, expected 1 0 1 0",
               done[2], busy[2], rdy[2], duty[2]);
    end
    advance();
    tests++;
    if (done[2] !== 1'b0 || busy[2] !== 1'b0) begin
      fails++;
      $display("FAIL same_duty_after: done=%b busy=%b, expected 0 0", done[2], busy[2]);
    end
  endtask

  task automatic test_div_and_immediate();
    cv[3] = 1'b1; cd[3] = 8'd2;
    advance();
    cv[3] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      ps[3] = 1'b1;
      advance();
      ps[3] = 1'b0;
      tests++;
      if (duty[3] !== 8'(j / 4) || done[3] !== (j == 8)) begin
        fails++;
        $display("FAIL div_seq[%0d]: duty=%0d done=%b, expected duty=%0d done=%b",
                 j, duty[3], done[3], j / 4, (j == 8));
      end
      advance();
    end
    cv[3] = 1'b1; cd[3] = 8'd200; ci[3] = 1'b1;
    advance();
    cv[3] = 1'b0; ci[3] = 1'b0;
    ps[3] = 1'b1;
    advance();
    ps[3] = 1'b0;
    tests++;
    if (duty[3] !== 8'd200 || done[3] !== 1'b1 || busy[3] !== 1'b0) begin
      fails++;
      $display("FAIL immediate: duty=%0d done=%b busy=%b, expected 200 1 0", duty[3], done[3], busy[3]);
    end
  endtask

  task automatic test_abort_and_held_cmd();
    cv[0] = 1'b1; cd[0] = 8'd10;
    advance();
    cd[0] = 8'd7;
    ps[0] = 1'b1;
    advance();
    ps[0] = 1'b0;
    tests++;
    if (duty[0] !== 8'd5 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: duty=%0d busy=%b, expected 5 1", duty[0], busy[0]);
    end
    advance();
    ps[0] = 1'b1; ab[0] = 1'b1;
    advance();
    ps[0] = 1'b0; ab[0] = 1'b0;
    tests++;
    if (duty[0] !== 8'd5 || busy[0] !== 1'b0 || rdy[0] !== 1'b1 || done[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort: duty=%0d busy=%b rdy=%b done=%b, expected 5 0 1 0",
               duty[0], busy[0], rdy[0], done[0]);
    end
    advance();
    cv[0] = 1'b0;
    tests++;
    if (busy[0] !== 1'b1 || duty[0] !== 8'd5) begin
      fails++;
      $display("FAIL held_accept: busy=%b duty=%0d, expected 1 5", busy[0], duty[0]);
    end
    for (int i = 0; i < 2; i++) begin
      ps[0] = 1'b1;
      advance();
      ps[0] = 1'b0;
      tests++;
      if (duty[0] !== 8'(6 + i) || done[0] !== (i == 1)) begin
        fails++;
        $display("FAIL held_ramp[%0d]: duty=%0d done=%b, expected duty=%0d done=%b",
                 i, duty[0], done[0], 6 + i, (i == 1));
      end
    end
    ab[0] = 1'b1;
    advance();
    ab[0] = 1'b0;
    tests++;
    if (duty[0] !== 8'd7 || busy[0] !== 1'b0 || rdy[0] !== 1'b1 || done[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: duty=%0d busy=%b rdy=%b done=%b, expected 7 0 1 0",
               duty[0], busy[0], rdy[0], done[0]);
    end
  endtask

  task automatic test_reset_midramp();
    cv[3] = 1'b1; cd[3] = 8'd100;
    advance();
    cv[3] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ps[3] = 1'b1;
      advance();
      ps[3] = 1'b0;
    end
    tests++;
    if (duty[3] !== 8'd199 || busy[3] !== 1'b1) begin
      fails++;
      $display("FAIL midramp_pre: duty=%0d busy=%b, expected 199 1", duty[3], busy[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (duty[3] !== 8'd0 || busy[3] !== 1'b0 || rdy[3] !== 1'b1 || done[3] !== 1'b0) begin
      fails++;
      $display("FAIL midramp_reset: duty=%0d busy=%b rdy=%b done=%b, expected 0 0 1 0",
               duty[3], busy[3], rdy[3], done[3]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ps[3] = 1'b1;
      advance();
      ps[3] = 1'b0;
      tests++;
      if (duty[3] !== 8'd0 || busy[3] !== 1'b0 || done[3] !== 1'b0 || duty[0] !== 8'd0) begin
        fails++;
        $display("FAIL post_reset[%0d]: duty3=%0d busy=%b done=%b duty0=%0d, expected 0 0 0 0",
                 i, duty[3], busy[3], done[3], duty[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        ps[k] = ($urandom_range(0, 2) == 0);
        cv[k] = ($urandom_range(0, 7) == 0);
        ci[k] = ($urandom_range(0, 5) == 0);
        ab[k] = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 3) == 0) cd[k] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
        else cd[k] = 8'($urandom_range(0, 255));
      end
      advance();
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (duty[k] !== 8'(m_duty[k]) || busy[k] !== m_busy[k] || rdy[k] !== !m_busy[k] ||
            done[k] !== m_done[k]) begin
          fails++;
          $display("FAIL random[%0d][%0d]: duty=%0d busy=%b rdy=%b done=%b, expected duty=%0d busy=%b rdy=%b done=%b",
                   c, k, duty[k], busy[k], rdy[k], done[k], m_duty[k], m_busy[k], !m_busy[k], m_done[k]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_step1_ramp();
    test_saturate_up();
    test_no_wrap_down();
    test_div_and_immediate();
    test_abort_and_held_cmd();
    test_reset_midramp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
